gray_updown_counter: RTL and testbench

GRAY_UPDOWN_COUNTER -- requirements
Module: gray_updown_counter

---
 rtl/gray_updown_counter.sv | 50 +++++
 tb/tb_gray_updown_counter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/gray_updown_counter.sv
// gray_updown_counter: up/down binary+Gray counter (clk, rst, en, dir, load, load_bin -> bin_q, gray_q, wrap_q, at_max, at_min, sat_hit, load_evt)
module gray_updown_counter #(
  parameter int WIDTH = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             wrap_q,
  output logic             at_max,
  output logic             at_min,
  output logic             sat_hit,
  output logic             load_evt
);
  localparam logic [WIDTH-1:0] MAX = '1;
  logic [WIDTH-1:0] step_bin, nxt_bin, nxt_gray;
  logic at_lim, blocked, nxt_wrap;
  always_comb begin
    at_lim   = dir ? (bin_q == MAX) : (bin_q == '0);
    blocked  = SATURATE && at_lim;
    step_bin = blocked ? bin_q : dir ? bin_q + 1'b1 : bin_q - 1'b1;
    nxt_bin  = load ? load_bin : en ? step_bin : bin_q;
    nxt_gray = nxt_bin ^ (nxt_bin >> 1);
    nxt_wrap = load ? 1'b0 : (en && at_lim && !blocked) ? ~wrap_q : wrap_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q    <= '0;
      gray_q   <= '0;
      wrap_q   <= 1'b0;
      at_max   <= 1'b0;
      at_min   <= 1'b1;
      sat_hit  <= 1'b0;
      load_evt <= 1'b0;
    end else begin
      bin_q    <= nxt_bin;
      gray_q   <= nxt_gray;
      wrap_q   <= nxt_wrap;
      at_max   <= nxt_bin == MAX;
      at_min   <= nxt_bin == '0;
      sat_hit  <= !load && en && blocked;
      load_evt <= load && (nxt_gray != gray_q);
    end
  end
endmodule

// File: tb/tb_gray_updown_counter.sv
// tb_gray_updown_counter: directed and randomized checks of gray_updown_counter
module tb_gray_updown_counter;
  logic clk = 1'b0;
  logic rst = 1'b0, en = 1'b0, dir = 1'b0, load = 1'b0;
  logic [3:0] lb4 = '0;
  logic [7:0] lb8 = '0;
  logic [3:0] b0, g0, b1, g1;
  logic [7:0] b2, g2;
  logic w0, mx0, mn0, s0, l0, w1, mx1, mn1, s1, l1, w2, mx2, mn2, s2, l2;
  int checks = 0, failures = 0;
  int gt [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
  always #5 clk = ~clk;
  gray_updown_counter #(.WIDTH(4), .SATURATE(1'b0)) u0 (.clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_bin(lb4), .bin_q(b0), .gray_q(g0), .wrap_q(w0), .at_max(mx0), .at_min(mn0), .sat_hit(s0), .load_evt(l0));
  gray_updown_counter #(.WIDTH(4), .SATURATE(1'b1)) u1 (.clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_bin(lb4), .bin_q(b1), .gray_q(g1), .wrap_q(w1), .at_max(mx1), .at_min(mn1), .sat_hit(s1), .load_evt(l1));
  gray_updown_counter #(.WIDTH(8), .SATURATE(1'b0)) u2 (.clk(clk), .rst(rst), .en(en), .dir(dir), .load(load),
    .load_bin(lb8), .bin_q(b2), .gray_q(g2), .wrap_q(w2), .at_max(mx2), .at_min(mn2), .sat_hit(s2), .load_evt(l2));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [3:0] pg;
    logic [7:0] mb, pg8;
    logic mw, nd;
    rst = 1'b1; load = 1'b1; lb4 = 4'd9; lb8 = 8'd9; en = 1'b1; dir = 1'b1;
    tick();
    check("rst_bin", b0, 0);
    check("rst_gray", g0, 0);
    check("rst_wrap", w0, 0);
    check("rst_min", mn0, 1);
    check("rst_max", mx0, 0);
    check("rst_sat", s1, 0);
    check("rst_levt", l0, 0);
    rst = 1'b0; load = 1'b0; en = 1'b0;
    tick();
    check("hold_bin", b0, 0);
    check("hold_levt", l0, 0);
    en = 1'b1; dir = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      pg = g0;
      tick();
      check("inc_bin", b0, i % 16);
      check("inc_gray", g0, gt[i % 16]);
      check("inc_1bit", $countones(pg ^ g0), 1);
      check("inc_max", mx0, (i == 15) ? 1 : 0);
    end
    check("inc_wrap", w0, 1);
    dir = 1'b0;
    tick();
    check("dec_bin", b0, 15);
    check("dec_gray", g0, 4'b1000);
    check("dec_wrap", w0, 0);
    check("dec_max", mx0, 1);
    check("dec_min", mn0, 0);
    en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; load = 1'b1; lb4 = 4'd5; en = 1'b1; dir = 1'b1;
    tick();
    check("ld_bin", b0, 5);
    check("ld_gray", g0, 4'b0111);
    check("ld_evt", l0, 1);
    check("ld_wrap", w0, 0);
    tick();
    check("ld_same_evt", l0, 0);
    check("ld_same_bin", b0, 5);
    load = 1'b0; en = 1'b0;
    tick();
    check("ld_idle_evt", l0, 0);
    load = 1'b1; lb4 = 4'd14;
    tick();
    check("sat_ld", b1, 14);
    load = 1'b0; en = 1'b1; dir = 1'b1;
    tick();
    check("sat_b1", b1, 15);
    check("sat_h1", s1, 0);
    tick();
    check("sat_b2", b1, 15);
    check("sat_h2", s1, 1);
    tick();
    check("sat_b3", b1, 15);
    check("sat_h3", s1, 1);
    check("sat_levt", l1, 0);
    check("sat_wrap", w1, 0);
    en = 1'b0;
    tick();
    check("sat_end", s1, 0);
    load = 1'b1; lb4 = 4'd0;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b0;
    tick();
    check("satmin_bin", b1, 0);
    check("satmin_hit", s1, 1);
    check("satmin_wrap", w1, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0; en = 1'b0;
    tick();
    check("rstmid_sat", s1, 0);
    check("rstmid_levt", l1, 0);
    en = 1'b1; dir = 1'b1;
    tick();
    check("post_rst_step", b1, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mb = '0; mw = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      en = 1'($urandom); dir = 1'($urandom);
      nd = en && (dir ? (mb == 8'hff) : (mb == 8'h00));
      mw = nd ? ~mw : mw;
      mb = en ? (dir ? mb + 8'd1 : mb - 8'd1) : mb;
      pg8 = g2;
      tick();
      check("rnd_bin", b2, mb);
      check("rnd_gray", g2, mb ^ (mb >> 1));
      check("rnd_wrap", w2, mw);
      check("rnd_1bit", ($countones(pg8 ^ g2) <= 1) ? 1 : 0, 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
